// File: rtl/prime_power_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prime_power_sequencer_pkg
// Brief    : Shared widths and state encoding for the prime-power sequencer.
// Revision : 1.0
// ============================================================================
package prime_power_sequencer_pkg;

  localparam int PPS_BOUND_W = 16;
  localparam int PPS_IDX_W   = 13;
  localparam int PPS_PRIME_W = 9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LIST = 3'd1,
    S_ADDR      = 3'd2,
    S_RD1       = 3'd3,
    S_RD2       = 3'd4,
    S_POWER     = 3'd5,
    S_EMIT      = 3'd6,
    S_FINISH    = 3'd7
  } pps_state_t;

endpackage
`default_nettype wire

// File: rtl/prime_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prime_power_sequencer
// Brief    : Walks a prime table and emits the largest power p^e <= B per prime.
// Revision : 1.0
// ============================================================================
module prime_power_sequencer
  import prime_power_sequencer_pkg::*;
#(
  parameter int BOUND_W = PPS_BOUND_W,
  parameter int IDX_W   = PPS_IDX_W,
  parameter int PRIME_W = PPS_PRIME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOUND_W-1:0] bound,
  input  logic               list_ready,
  output logic [IDX_W-1:0]   list_index,
  input  logic [PRIME_W-1:0] list_data,
  output logic               pp_valid,
  input  logic               pp_ready,
  output logic [BOUND_W-1:0] pp_data,
  output logic [PRIME_W-1:0] pp_prime,
  output logic               busy,
  output logic               done
);

  localparam int PROD_W = BOUND_W + PRIME_W;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  pps_state_t         state;
  logic [BOUND_W-1:0] b_reg;
  logic [BOUND_W-1:0] acc;
  logic [PRIME_W-1:0] p_reg;

  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] data_ext;

  // Full-width product so the bound compare never sees a wrapped value.
  assign product  = {{PRIME_W{1'b0}}, acc} * {{BOUND_W{1'b0}}, p_reg};
  assign b_ext    = {{PRIME_W{1'b0}}, b_reg};
  assign data_ext = {{BOUND_W{1'b0}}, list_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      b_reg      <= '0;
      acc        <= '0;
      p_reg      <= '0;
      list_index <= '0;
      pp_valid   <= 1'b0;
      pp_data    <= '0;
      pp_prime   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            b_reg      <= bound;
            list_index <= IDX_ONE;
            busy       <= 1'b1;
            if (bound[BOUND_W-1:1] == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT_LIST;
            end
          end
        end
        S_WAIT_LIST: if (list_ready) state <= S_ADDR;
        S_ADDR:      state <= S_RD1;
        S_RD1:       state <= S_RD2;
        S_RD2: begin
          p_reg <= list_data;
          if (list_data == '0 || data_ext > b_ext) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            acc   <= data_ext[BOUND_W-1:0];
            state <= S_POWER;
          end
        end
        S_POWER: begin
          if (product <= b_ext) begin
            acc <= product[BOUND_W-1:0];
          end else begin
            pp_valid <= 1'b1;
            pp_data  <= acc;
            pp_prime <= p_reg;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pp_ready) begin
            pp_valid <= 1'b0;
            if (&list_index) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              list_index <= list_index + IDX_ONE;
              state      <= S_ADDR;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prime_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_power_sequencer
// Brief    : Random and directed checks of the sequencer against a table model.
// Revision : 1.0
// ============================================================================
module tb_prime_power_sequencer;

  localparam int BOUND_W = 16;
  localparam int IDX_W   = 4;
  localparam int PRIME_W = 9;
  localparam int MAX_IDX = (1 << IDX_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [BOUND_W-1:0] bound;
  logic               list_ready;
  logic [IDX_W-1:0]   list_index;
  logic [PRIME_W-1:0] list_data;
  logic               pp_valid;
  logic               pp_ready;
  logic [BOUND_W-1:0] pp_data;
  logic [PRIME_W-1:0] pp_prime;
  logic               busy;
  logic               done;

  int vectors = 0;
  int miscompares = 0;

  logic [PRIME_W-1:0] mem [0:MAX_IDX];
  logic [PRIME_W-1:0] d1 = '0;
  logic [PRIME_W-1:0] d2 = '0;

  int exp_data[$];
  int exp_prime[$];
  int lat_exp;

  prime_power_sequencer #(
    .BOUND_W(BOUND_W), .IDX_W(IDX_W), .PRIME_W(PRIME_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bound(bound),
    .list_ready(list_ready), .list_index(list_index), .list_data(list_data),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data),
    .pp_prime(pp_prime), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Prime table with two-clock read latency.
  always @(posedge clk) begin
    d1 <= mem[list_index];
    d2 <= d1;
  end
  assign list_data = d2;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_table(input int vals[$]);
    for (int i = 0; i <= MAX_IDX; i++) mem[i] = '0;
    mem[0] = 9'd7;
    for (int i = 0; i < vals.size() && i < MAX_IDX; i++) mem[i+1] = PRIME_W'(vals[i]);
  endtask

  // Largest power of each table entry not exceeding B, in table order.
  task automatic build_model(input longint b);
    exp_data.delete();
    exp_prime.delete();
    lat_exp = -1;
    if (b < 2) return;
    for (int i = 1; i <= MAX_IDX; i++) begin
      longint p, pw;
      int steps;
      p = longint'(mem[i]);
      if (p == 0 || p > b) break;
      pw = p;
      steps = 0;
      while (pw * p <= b) begin
        pw = pw * p;
        steps++;
      end
      if (i == 1) lat_exp = 6 + steps;
      exp_data.push_back(int'(pw));
      exp_prime.push_back(int'(p));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, pp_valid, 0);
    check({tag, "_data"}, pp_data, 0);
    check({tag, "_prime"}, pp_prime, 0);
    check({tag, "_index"}, list_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 first item stalled 10 cycles.
  task automatic run_seq(input int b, input int ready_mode, input bit lr_delay,
                         input bit noise);
    int cnt, stall, transfers;
    bit got_done, first_pending, hold;
    logic [BOUND_W-1:0] hdata;
    logic [PRIME_W-1:0] hprime;
    build_model(longint'(b));
    cnt = 0; stall = 0; transfers = 0;
    got_done = 0; first_pending = 1; hold = 0;
    hdata = '0; hprime = '0;
    @(negedge clk);
    list_ready = !lr_delay;
    pp_ready = (ready_mode == 0);
    start = 1'b1;
    bound = BOUND_W'(b);
    while (!got_done && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (lr_delay && cnt == 7) list_ready = 1'b1;
      if (hold) begin
        check("hold_data", pp_data, hdata);
        check("hold_prime", pp_prime, hprime);
      end
      if (pp_valid && first_pending) begin
        if (!lr_delay) check("first_latency", cnt, lat_exp);
        first_pending = 0;
      end
      check("busy_high", busy, 1);
      if (done) begin
        got_done = 1;
        check("items_left_at_done", exp_data.size(), 0);
        check("valid_at_done", pp_valid, 0);
        if (b < 2) check("short_done_latency", cnt, 1);
      end
      case (ready_mode)
        0: pp_ready = 1'b1;
        1: pp_ready = ($urandom_range(0, 2) != 0);
        default: begin
          pp_ready = pp_valid && (stall >= 10);
          if (pp_valid) stall++;
        end
      endcase
      if (pp_valid && pp_ready) begin
        transfers++;
        check("item_expected", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) begin
          check("pp_data", pp_data, exp_data.pop_front());
          check("pp_prime", pp_prime, exp_prime.pop_front());
        end
      end
      hold = pp_valid && !pp_ready;
      hdata = pp_data;
      hprime = pp_prime;
      start = (noise && !got_done) ? ($urandom_range(0, 7) == 0) : 1'b0;
      bound = BOUND_W'($urandom);
    end
    if (!got_done) check("done_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    check("busy_after_finish", busy, 0);
    check("done_one_cycle", done, 0);
    check("valid_after_finish", pp_valid, 0);
  endtask

  initial begin
    int vals[$];
    rst = 1'b1; start = 1'b0; bound = '0; list_ready = 1'b0; pp_ready = 1'b0;
    load_table('{2, 3, 5, 7, 11});
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    load_table('{2, 3, 5, 7, 11});
    run_seq(10, 0, 0, 0);
    run_seq(1, 0, 0, 0);
    run_seq(0, 0, 0, 0);
    load_table('{2, 3, 5});
    run_seq(30, 2, 0, 0);
    load_table('{2, 3});
    run_seq(65535, 0, 0, 0);
    run_seq(100, 1, 1, 1);

    // Reset during POWER for p=2, B=1000.
    load_table('{2, 3, 5, 7});
    @(negedge clk);
    list_ready = 1'b1; start = 1'b1; bound = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("in_power_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_power");
    rst = 1'b0;
    run_seq(1000, 0, 0, 0);

    // Reset while an item waits in EMIT; it must not reappear.
    @(negedge clk);
    pp_ready = 1'b0; start = 1'b1; bound = 16'd30;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !pp_valid; i++) @(negedge clk);
    check("emit_reached", pp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_emit");
    rst = 1'b0;
    @(negedge clk);
    check("no_reemit", pp_valid, 0);

    // Every table slot populated: sequence ends at the last index.
    load_table('{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47});
    run_seq(65535, 1, 0, 1);

    for (int t = 0; t < 25; t++) begin
      int n, b;
      vals.delete();
      n = $urandom_range(0, MAX_IDX);
      for (int i = 0; i < n; i++)
        vals.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(2, 511)
                                                   : $urandom_range(2, 60));
      load_table(vals);
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 20);
        1: b = $urandom_range(2, 1000);
        2: b = $urandom_range(0, 65535);
        default: b = 65535;
      endcase
      run_seq(b, $urandom_range(0, 2), $urandom_range(0, 1) == 1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
